// File: rtl/binary_mul_pkg.sv
// Shared widths and operand/product types for the binary multiplier family.
package binary_mul_pkg;
    localparam int unsigned MUL_W  = 6;
    localparam int unsigned PROD_W = 12;

    typedef logic [MUL_W-1:0]  operand_t;
    typedef logic [PROD_W-1:0] product_t;
endpackage

// File: rtl/binary_mul_fa.sv
// 1-bit full adder cell; used with cin tied low as a half adder.
module binary_mul_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/binary_mul_6_1_uni.sv
// Unsigned 6x6 multiplier with one registered output stage.
// Define BINARY_MUL_CSA_TREE_EN for a carry-save tree; default is a ripple array.
module binary_mul_6_1_uni
    import binary_mul_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    input  operand_t A,
    input  operand_t B,
    output product_t P
);
    operand_t pp [0:MUL_W-1];
    product_t prod;

    for (genvar i = 0; i < MUL_W; i++) begin : g_pp
        assign pp[i] = A & {MUL_W{B[i]}};
    end

`ifdef BINARY_MUL_CSA_TREE_EN
    product_t row [0:MUL_W-1];
    product_t cx  [0:3];
    product_t cy  [0:3];
    product_t cz  [0:3];
    product_t cs  [0:3];
    product_t cco [0:3];
    product_t fy;
    logic [PROD_W:0] rc;

    for (genvar i = 0; i < MUL_W; i++) begin : g_row
        assign row[i] = product_t'({6'b0, pp[i]}) << i;
    end

    // 6 rows -> 4 -> 3 -> 2, carries shifted up one weight between levels
    assign cx[0] = row[0];
    assign cy[0] = row[1];
    assign cz[0] = row[2];
    assign cx[1] = row[3];
    assign cy[1] = row[4];
    assign cz[1] = row[5];
    assign cx[2] = cs[0];
    assign cy[2] = {cco[0][PROD_W-2:0], 1'b0};
    assign cz[2] = cs[1];
    assign cx[3] = cs[2];
    assign cy[3] = {cco[2][PROD_W-2:0], 1'b0};
    assign cz[3] = {cco[1][PROD_W-2:0], 1'b0};

    for (genvar n = 0; n < 4; n++) begin : g_csa
        for (genvar b = 0; b < PROD_W; b++) begin : g_bit
            binary_mul_fa u_fa (
                .a    (cx[n][b]),
                .b    (cy[n][b]),
                .cin  (cz[n][b]),
                .sum  (cs[n][b]),
                .cout (cco[n][b])
            );
        end
    end

    assign fy    = {cco[3][PROD_W-2:0], 1'b0};
    assign rc[0] = 1'b0;
    for (genvar b = 0; b < PROD_W; b++) begin : g_final
        binary_mul_fa u_fa (
            .a    (cs[3][b]),
            .b    (fy[b]),
            .cin  (rc[b]),
            .sum  (prod[b]),
            .cout (rc[b+1])
        );
    end
`else
    // Each row keeps only its upper 6 bits; its LSB retires as a product bit.
    operand_t   hi [0:MUL_W-1];
    operand_t   rs [1:MUL_W-1];
    logic [6:0] rc [1:MUL_W-1];

    assign hi[0]   = {1'b0, pp[0][MUL_W-1:1]};
    assign prod[0] = pp[0][0];

    for (genvar k = 1; k < MUL_W; k++) begin : g_rowk
        assign rc[k][0] = 1'b0;
        for (genvar j = 0; j < MUL_W; j++) begin : g_cell
            binary_mul_fa u_fa (
                .a    (hi[k-1][j]),
                .b    (pp[k][j]),
                .cin  (rc[k][j]),
                .sum  (rs[k][j]),
                .cout (rc[k][j+1])
            );
        end
        assign hi[k]   = {rc[k][MUL_W], rs[k][MUL_W-1:1]};
        assign prod[k] = rs[k][0];
    end

    assign prod[PROD_W-1:MUL_W] = hi[MUL_W-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P <= '0;
        end else if (en) begin
            P <= prod;
        end
    end
endmodule

// File: tb/tb_binary_mul_6_1_uni.sv
// Directed self-checking bench for binary_mul_6_1_uni.
module tb_binary_mul_6_1_uni;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic [5:0]  A;
    logic [5:0]  B;
    logic [11:0] P;

    int unsigned checks = 0;
    int unsigned errors = 0;

    binary_mul_6_1_uni dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (A),
        .B     (B),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        A     = 6'd63;
        B     = 6'd63;
        #1;
        checks++;
        if (P !== 12'd0) begin
            errors++;
            $display("FAIL reset_initial: P=%0d expected 0", P);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (P !== 12'd0) begin
                errors++;
                $display("FAIL reset_hold: P=%0d expected 0", P);
            end
        end
    endtask

    task automatic test_basic_capture();
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        A     = 6'd63;
        B     = 6'd63;
        @(posedge clk);
        #1;
        checks++;
        if (P !== 12'd3969) begin
            errors++;
            $display("FAIL basic_capture: P=%0d expected 3969", P);
        end
    endtask

    task automatic test_enable_hold();
        @(negedge clk);
        en = 1'b1;
        A  = 6'd5;
        B  = 6'd7;
        @(posedge clk);
        #1;
        checks++;
        if (P !== 12'd35) begin
            errors++;
            $display("FAIL enable_capture: P=%0d expected 35", P);
        end
        @(negedge clk);
        en = 1'b0;
        A  = 6'd60;
        B  = 6'd60;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (P !== 12'd35) begin
                errors++;
                $display("FAIL enable_hold: edge %0d P=%0d expected 35", i, P);
            end
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (P !== 12'd3600) begin
            errors++;
            $display("FAIL enable_resume: P=%0d expected 3600", P);
        end
    endtask

    task automatic test_zero_identity();
        logic [5:0]  va [4] = '{6'd0, 6'd1, 6'd45, 6'd32};
        logic [5:0]  vb [4] = '{6'd45, 6'd45, 6'd1, 6'd2};
        logic [11:0] ve [4] = '{12'd0, 12'd45, 12'd45, 12'd64};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en = 1'b1;
            A  = va[i];
            B  = vb[i];
            @(posedge clk);
            #1;
            checks++;
            if (P !== ve[i]) begin
                errors++;
                $display("FAIL zero_identity: A=%0d B=%0d P=%0d expected %0d",
                         va[i], vb[i], P, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned bad = 0;
        logic [11:0] exp_p;
        en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                @(negedge clk);
                A = 6'(i);
                B = 6'(j);
                exp_p = 12'(i * j);
                @(posedge clk);
                #1;
                checks++;
                if (P !== exp_p) begin
                    errors++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL sweep: A=%0d B=%0d P=%0d expected %0d",
                                 i, j, P, exp_p);
                end
            end
        end
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        en = 1'b1;
        A  = 6'd63;
        B  = 6'd63;
        @(posedge clk);
        #1;
        checks++;
        if (P !== 12'd3969) begin
            errors++;
            $display("FAIL midrun_pre: P=%0d expected 3969", P);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (P !== 12'd0) begin
            errors++;
            $display("FAIL midrun_async_clear: P=%0d expected 0", P);
        end
        A = 6'd3;
        B = 6'd4;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (P !== 12'd12) begin
            errors++;
            $display("FAIL midrun_recapture: P=%0d expected 12", P);
        end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_enable_hold();
        test_zero_identity();
        test_back_to_back();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
